// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: turns a valid/ready command stream into APB transfers
// and returns one registered response (read data, slave error, timeout) per command.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pslver
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TimeoutEn = (TIMEOUT != 0);
  // Counter value seen during the final permitted ACCESS cycle.
  localparam logic [CntW-1:0] WaitLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  assign cmd_ready = (state_q == StIdle) && (!rsp_valid_q || rsp_ready);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q && !rsp_ready;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          wait_d    = '0;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        wait_d    = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        if (pready) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslver;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = StIdle;
        end else if (TimeoutEn && (wait_q == WaitLast)) begin
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = StIdle;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wait_q        <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: a reactive APB slave with a word memory, and a
// transaction-level model predicting per-command latency, response fields and backpressure.
module tb_apb_master_bridge;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned To = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslver;

  apb_master_bridge #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(To)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .prdata     (prdata),
    .pslver     (pslver)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  logic [DW-1:0] mem [256];
  logic          pend;
  logic [DW-1:0] last_rdata;
  logic          last_err, last_to;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One command: optional response backpressure first, then the APB transfer with nwait
  // pready-low ACCESS cycles; rst_at>0 pulses reset during that ACCESS cycle instead.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int nwait, input logic serr, input int hold, input int rst_at);
    int            cycles;
    logic          tmo;
    logic [DW-1:0] exp_rd;
    cmd_valid = 1'b1;
    if (pend) begin
      for (int i = 0; i < hold; i++) begin
        rsp_ready = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        #1;
        check_eq("cmd_ready_blocked", cmd_ready, 0);
        step();
        check_eq("psel_blocked", psel, 0);
        check_eq("rsp_valid_held", rsp_valid, 1);
        check_eq("rsp_rdata_held", rsp_rdata, last_rdata);
        check_eq("rsp_flags_held", {rsp_err, rsp_timeout}, {last_err, last_to});
      end
    end
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    rsp_ready = 1'b1;
    #1;
    check_eq("cmd_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    check_eq("rsp_consumed", rsp_valid, 0);
    check_eq("setup_sel_en", {psel, penable}, 2'b10);
    check_eq("setup_paddr", paddr, addr);
    check_eq("setup_pwrite", pwrite, wr);
    check_eq("setup_pwdata", pwdata, wd);
    tmo    = (To != 0) && (nwait >= int'(To));
    cycles = tmo ? int'(To) : nwait + 1;
    for (int k = 1; k <= cycles; k++) begin
      step();
      check_eq("access_sel_en", {psel, penable}, 2'b11);
      check_eq("access_addr_dir", {pwrite, paddr}, {wr, addr});
      check_eq("access_pwdata", pwdata, wd);
      if (k == rst_at) begin
        rst    = 1'b1;
        pready = 1'b0;
        step();
        rst = 1'b0;
        check_eq("rst_apb", {psel, penable, pwrite, paddr, pwdata}, 0);
        check_eq("rst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
        pend = 1'b0;
        return;
      end
      pready = (k == nwait + 1);
      pslver = pready ? serr : 1'($urandom);
      prdata = pready ? mem[addr] : $urandom;
    end
    exp_rd = (tmo || wr) ? '0 : mem[addr];
    step();
    pready = 1'b0;
    pslver = 1'($urandom);
    prdata = $urandom;
    check_eq("done_sel_en", {psel, penable}, 2'b00);
    check_eq("rsp_valid", rsp_valid, 1);
    check_eq("rsp_rdata", rsp_rdata, exp_rd);
    check_eq("rsp_err", rsp_err, tmo ? 1'b1 : serr);
    check_eq("rsp_timeout", rsp_timeout, tmo);
    if (wr && !tmo && !serr) mem[addr] = wd;
    pend       = 1'b1;
    last_rdata = exp_rd;
    last_err   = tmo ? 1'b1 : serr;
    last_to    = tmo;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          wr, serr;
    logic [AW-1:0] addr;
    int            nwait, hold, rst_at;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; pready = 1'b0; prdata = '0; pslver = 1'b0; pend = 1'b0;
    last_rdata = '0; last_err = 1'b0; last_to = 1'b0;
    step();
    step();
    check_eq("reset_apb", {psel, penable, pwrite, paddr, pwdata}, 0);
    check_eq("reset_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, 0);
    rst = 1'b0;

    run_cmd(1'b1, 8'd5, 32'h1, 0, 1'b0, 0, 0);
    run_cmd(1'b0, 8'd5, 32'h0, 0, 1'b0, 0, 0);
    check_eq("read_back_5", rsp_rdata, 32'h1);
    mem[8] = 32'hDEADBEEF;
    run_cmd(1'b0, 8'd8, 32'h0, 3, 1'b0, 0, 0);
    run_cmd(1'b1, 8'd9, 32'h1234_5678, 0, 1'b1, 0, 0);
    run_cmd(1'b0, 8'd3, 32'h0, 40, 1'b0, 0, 0);
    run_cmd(1'b0, 8'd3, 32'h0, int'(To) - 1, 1'b0, 0, 0);
    run_cmd(1'b1, 8'd7, 32'hCAFE_F00D, 0, 1'b0, 5, 0);
    run_cmd(1'b0, 8'd7, 32'h0, 0, 1'b0, 5, 0);
    run_cmd(1'b0, 8'd2, 32'h0, 10, 1'b0, 0, 3);
    run_cmd(1'b0, 8'd7, 32'h0, 1, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      wr     = 1'($urandom);
      addr   = AW'($urandom_range(0, 15));
      nwait  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(To - 2, To + 2))
                                           : int'($urandom_range(0, 4));
      serr   = ($urandom_range(0, 3) == 0);
      hold   = int'($urandom_range(0, 3));
      rst_at = ($urandom_range(0, 11) == 0) ? 1 : 0;
      run_cmd(wr, addr, $urandom, nwait, serr, hold, rst_at);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream neighbour of the APB slave memory: converts a simple valid/ready command stream into single APB transfers.
- Drives psel/penable/pwrite/paddr/pwdata, samples pready/prdata/pslver.
- Returns one response per command: read data, slave-error flag and timeout flag.
- Sits between the system/test command source and the APB slave. One outstanding transfer at a time.

Parameters:
- ADDR_W, 8, width of paddr/cmd_addr.
- DATA_W, 32, width of pwdata/prdata/cmd_wdata/rsp_rdata.
- TIMEOUT, 16, max consecutive ACCESS cycles without pready before abort; 0 disables timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command this cycle.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data (ignored for reads).
- rsp_valid  out  1  response available, held until rsp_ready.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  pslver sampled at completion, or 1 on timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_W  slave read data.
- pslver  in  1  slave error.

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, wait counter=0. Outputs after that edge: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
- Reset asserted mid-SETUP/ACCESS aborts the transfer with no response; a pending response is dropped.
- All APB outputs and rsp_* are registered. cmd_ready is combinational: (state==IDLE) && (!rsp_valid || rsp_ready).
- States:
  - IDLE: psel=0, penable=0. On cmd_valid && cmd_ready at edge N, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, go to SETUP.
  - SETUP: psel=1, penable=0 for exactly one cycle, then ACCESS. Wait counter cleared.
  - ACCESS: psel=1, penable=1. At each edge:
    - pready=1: rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslver, rsp_timeout=0, rsp_valid=1, go to IDLE.
    - Else, if TIMEOUT!=0 and this is the TIMEOUT-th consecutive ACCESS cycle: rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1, go to IDLE.
    - Else increment the wait counter and stay.
    - pready on the TIMEOUT-th cycle completes normally (pready wins).
- Latency with zero wait states: accept at edge N; psel=1 after N; penable=1 after N+1; completion at N+2; psel=penable=0 and rsp_valid=1 after N+2. Each pready=0 cycle adds one cycle.
- paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS and keep their last values in IDLE. psel and penable never go high in IDLE.
- Response handshake: rsp_valid clears on an edge with rsp_ready=1 unless a new completion occurs on the same edge (impossible: a new completion needs at least 2 cycles).
  - New commands are blocked while the response is unconsumed; rsp_ready in the same cycle re-enables cmd_ready.
  - Back-to-back throughput is one transfer per 3 cycles.
- cmd_* are sampled only on accept; changes while cmd_ready=0 are ignored.
- Wait counter width: clog2(TIMEOUT+1). It never wraps because it is bounded by TIMEOUT.

Test Plan:
- Zero-wait write then read, pready tied 1, rsp_ready=1:
  - Write addr 5 data 32'h1 -> psel after N, penable after N+1, rsp_valid after N+2 with rsp_err=0, rdata=0.
  - Read addr 5 -> rsp_rdata=32'h1.
- Wait states: slave holds pready=0 for 3 ACCESS cycles on a read of addr 8 returning 32'hDEADBEEF -> penable high 4 cycles, paddr stable, rsp_rdata=32'hDEADBEEF, rsp_timeout=0.
- Slave error: pready=1 with pslver=1 on a write -> rsp_valid=1, rsp_err=1, rsp_timeout=0, psel/penable=0 next cycle.
- Timeout: TIMEOUT=16, pready stuck 0 -> exactly 16 ACCESS cycles, then psel=penable=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Variant with pready=1 on the 16th cycle -> normal completion.
- Response backpressure: rsp_ready=0 for 5 cycles after a completion with cmd_valid held -> cmd_ready=0, psel stays 0, rsp_* stable. Raising rsp_ready -> cmd_ready=1 same cycle and the next command is accepted.
- Reset mid-ACCESS (pready=0): rst=1 for one edge -> all outputs 0 after that edge, no rsp_valid. The next command completes normally.
